uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
// - Shares one uart_controller transmitter between NUM_REQ byte producers (e.g. debug console, status reporter, loopback echo).
// - Per-requester valid/ready handshake; round-robin selection.
// - Drives the uart_controller TX inputs (i_Tx_Byte, i_Tx_Ready); issues one byte per frame and waits for o_Tx_Done.
// PARAMETERS
// - NUM_REQ  4  number of requesters, 2..8
// - DATA_W   8  byte width; must match uart_controller
// - IDX_W    $clog2(NUM_REQ)  localparam, grant index width
// PORTS
// - clk          in   1               system clock
// - reset_n      in   1               async active-low reset
// - i_Req_Valid  in   NUM_REQ         requester k holds a byte
// - i_Req_Byte   in   NUM_REQ*DATA_W  byte k at [k*DATA_W +: DATA_W]
// - i_Req_Last   in   NUM_REQ         last byte of message (used only with UART_ARB_LOCK_EN)
// - o_Req_Ready  out  NUM_REQ         one-cycle pulse: byte k accepted
// - o_Tx_Byte    out  DATA_W          to uart_controller i_Tx_Byte
// - o_Tx_Ready   out  1               to uart_controller i_Tx_Ready, one-cycle pulse
// - i_Tx_Done    in   1               from uart_controller o_Tx_Done
// - o_Grant      out  IDX_W           index of current/last granted requester
// - o_Busy       out  1               high outside IDLE
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, rr pointer 0, lock cleared; reset mid-frame abandons the frame, no replay.
// - FSM: IDLE -> SEND -> WAIT -> IDLE.
// - IDLE: if any i_Req_Valid, pick first valid at/after rr pointer (modulo NUM_REQ); capture byte into o_Tx_Byte, o_Grant=k, rr pointer=k+1 (wraps), go SEND.
// - SEND (1 cycle): o_Tx_Ready=1, o_Req_Ready[k]=1; go WAIT. Latency valid-in-IDLE to o_Tx_Ready: 1 clock.
// - WAIT: hold o_Tx_Byte; on i_Tx_Done go IDLE. i_Tx_Done is ignored in IDLE/SEND.
// - Requester holds valid+byte stable until it sees o_Req_Ready; it may present the next byte the cycle after.
// - Throughput: 1 byte per frame + 2 clocks (SEND + IDLE).
// - No valid: stay IDLE, outputs hold, o_Tx_Ready=0.
// - Valid dropped before acceptance: legal; it is not sampled outside IDLE.
// - Single requester: it is granted back-to-back; pointer wrap is harmless.
// CONFIGURATION
// - UART_ARB_LOCK_EN defined: a grant locks to k until a byte with i_Req_Last[k]=1 is accepted.
// - While locked, IDLE considers only k. If k is not valid, stall in IDLE; other requesters wait.
// - The lock clears on acceptance of the last byte, or on reset.
// - Undefined: every byte is arbitrated independently, and i_Req_Last is ignored.
// STRUCTURE
// - Package uart_arb_pkg: state enum (IDLE, SEND, WAIT), NUM_REQ max constant, byte typedef.
// - Sub-module uart_rr_picker: combinational; inputs valid vector + pointer; outputs found flag + index.
// - Top file holds the FSM, capture registers and lock flag.
// TESTING (25 MHz clk, 115200 baud, uart_controller in loopback, 217 clk/bit)
// - Single req0 sends 8'h55 -> o_Tx_Ready 1 clk after valid; Rx_Byte=8'h55; o_Req_Ready[0] exactly once.
// - All 4 valid at once (8'h01/8'h10/8'h22/8'h32) -> RX order 01,10,22,32.
//   Then with req1, req3 still valid -> order 1,3.
// - req2 streams 8 bytes alone -> 8 back-to-back frames, no gaps beyond 2 clk, no drops or duplicates.
// - reset_n low mid-WAIT -> all outputs 0 in the same cycle.
//   After release, pending req0 byte 8'hAA is sent next (pointer 0).
// - LOCK_EN: req0 sends 3 bytes (last on 3rd), req1 valid throughout -> 3 req0 bytes first, then req1.
// - LOCK_EN off: same stimulus -> bytes alternate req0/req1.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and limits for the UART transmit arbiter.
// Contents:
//   NUM_REQ_MAX  - largest supported requester count
//   BYTE_W       - nominal UART byte width
//   byte_t       - one UART byte
//   arb_state_t  - arbiter FSM states (IDLE, SEND, WAIT)
package uart_arb_pkg;

    localparam int unsigned NUM_REQ_MAX = 8;
    localparam int unsigned BYTE_W      = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: finds the first set bit of the valid
// vector at or after the pointer, wrapping modulo NUM_REQ.
// Ports:
//   valid    in   NUM_REQ  candidate vector
//   ptr      in   IDX_W    search start position
//   found_c  out  1        at least one candidate is set
//   idx_c    out  IDX_W    index of the chosen candidate (0 when none)
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found_c,
    output logic [IDX_W-1:0]   idx_c
);

    logic [IDX_W-1:0] cand;

    // Walk the offsets in priority order; the first hit wins.
    always_comb begin
        found_c = 1'b0;
        idx_c   = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!found_c && valid[cand]) begin
                found_c = 1'b1;
                idx_c   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte producers using a
// round-robin grant. One byte is issued per frame; the next grant waits
// for the transmitter's done pulse.
// Optional feature: define UART_ARB_LOCK_EN to keep the grant on one
// requester until it delivers a byte flagged with i_Req_Last.
// Ports:
//   clk          in   1               system clock
//   reset_n      in   1               async active-low reset
//   i_Req_Valid  in   NUM_REQ         requester k holds a byte
//   i_Req_Byte   in   NUM_REQ*DATA_W  byte k at [k*DATA_W +: DATA_W]
//   i_Req_Last   in   NUM_REQ         last byte of message (lock build only)
//   o_Req_Ready  out  NUM_REQ         one-cycle pulse: byte k accepted
//   o_Tx_Byte    out  DATA_W          byte to the transmitter
//   o_Tx_Ready   out  1               one-cycle start pulse to the transmitter
//   i_Tx_Done    in   1               transmitter frame complete
//   o_Grant      out  IDX_W           current/last granted requester
//   o_Busy       out  1               high outside IDLE
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned DATA_W  = 8,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        i_Req_Valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]        i_Req_Last,
    output logic [NUM_REQ-1:0]        o_Req_Ready,
    output logic [DATA_W-1:0]         o_Tx_Byte,
    output logic                      o_Tx_Ready,
    input  logic                      i_Tx_Done,
    output logic [IDX_W-1:0]          o_Grant,
    output logic                      o_Busy
);

    if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX) begin : g_cfg_check
        $error("uart_tx_arbiter: NUM_REQ out of range");
    end

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] eligible;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   next_ptr;

`ifdef UART_ARB_LOCK_EN
    logic locked;

    // While locked, only the owner (held in o_Grant) may be picked.
    always_comb begin
        eligible = i_Req_Valid;
        if (locked) begin
            eligible = i_Req_Valid & (NUM_REQ'(1) << o_Grant);
        end
    end

    // The requester holds its byte and last flag stable until accepted,
    // so sampling the flag at capture equals sampling it at acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked <= 1'b0;
        end else if (state == IDLE && pick_found) begin
            locked <= !i_Req_Last[pick_idx];
        end
    end
`else
    logic unused_last;

    assign unused_last = ^i_Req_Last;

    always_comb begin
        eligible = i_Req_Valid;
    end
`endif

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid   (eligible),
        .ptr     (rr_ptr),
        .found_c (pick_found),
        .idx_c   (pick_idx)
    );

    assign next_ptr = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : IDX_W'(pick_idx + 1'b1);

    // Arbiter FSM; strobes default low and are raised only on entry to SEND.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            o_Req_Ready <= '0;
            o_Tx_Byte   <= '0;
            o_Tx_Ready  <= 1'b0;
            o_Grant     <= '0;
            o_Busy      <= 1'b0;
        end else begin
            o_Tx_Ready  <= 1'b0;
            o_Req_Ready <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        o_Tx_Byte   <= i_Req_Byte[32'(pick_idx) * DATA_W +: DATA_W];
                        o_Grant     <= pick_idx;
                        rr_ptr      <= next_ptr;
                        o_Tx_Ready  <= 1'b1;
                        o_Req_Ready <= NUM_REQ'(1) << pick_idx;
                        o_Busy      <= 1'b1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (i_Tx_Done) begin
                        o_Busy <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    o_Busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. Requesters are modelled as byte
// queues, the transmitter as a fixed-length frame that ends in a done pulse.
// Expected {grant, byte} pairs go into a scoreboard queue as stimulus is
// loaded and are popped on every o_Tx_Ready pulse.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int NREQ      = 4;
    localparam int DW        = 8;
    localparam int IW        = 2;
    localparam int FRAME     = 20;
    localparam int DRAIN_MAX = 3000;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b1;
    logic [NREQ-1:0]      i_Req_Valid = '0;
    logic [NREQ*DW-1:0]   i_Req_Byte = '0;
    logic [NREQ-1:0]      i_Req_Last = '0;
    logic [NREQ-1:0]      o_Req_Ready;
    logic [DW-1:0]        o_Tx_Byte;
    logic                 o_Tx_Ready;
    logic                 i_Tx_Done = 1'b0;
    logic [IW-1:0]        o_Grant;
    logic                 o_Busy;

    uart_tx_arbiter #(
        .NUM_REQ (NREQ),
        .DATA_W  (DW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_Req_Valid (i_Req_Valid),
        .i_Req_Byte  (i_Req_Byte),
        .i_Req_Last  (i_Req_Last),
        .o_Req_Ready (o_Req_Ready),
        .o_Tx_Byte   (o_Tx_Byte),
        .o_Tx_Ready  (o_Tx_Ready),
        .i_Tx_Done   (i_Tx_Done),
        .o_Grant     (o_Grant),
        .o_Busy      (o_Busy)
    );

    typedef struct packed {
        logic [1:0] g;
        byte_t      b;
    } exp_t;

    typedef struct packed {
        logic            rst;
        logic [3:0]      mask;
        logic [3:0][7:0] bytes;
        logic [2:0]      n;
        logic [3:0][1:0] eg;
        logic [3:0][7:0] eb;
    } vec_t;

    exp_t        exp_q[$];
    logic [8:0]  rq[NREQ][$];
    vec_t        vt[6];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acc_cnt[NREQ];
    int          present_cyc[NREQ];
    int          tx_cyc = 0;
    int          done_cyc = 0;
    bit          done_seen = 1'b0;
    bit          gap_chk = 1'b0;
    bit          abort = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int k = 0; k < NREQ; k++) s += rq[k].size();
        return s;
    endfunction

    // Scoreboard monitor and requester model, both on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                if (o_Tx_Ready || o_Req_Ready != '0)
                    check("req_ready_onehot", 32'(o_Req_Ready), o_Tx_Ready ? (32'd1 << o_Grant) : 32'd0);
                if (o_Tx_Ready) begin
                    tx_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_tx: got grant %0d byte %0h, expected no transfer", o_Grant, o_Tx_Byte);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", 32'(o_Tx_Byte), 32'(e.b));
                        check("tx_grant", 32'(o_Grant), 32'(e.g));
                    end
                    if (gap_chk && done_seen)
                        check("frame_gap", 32'(cyc - done_cyc), 32'd2);
                end
                for (int k = 0; k < NREQ; k++) begin
                    if (o_Req_Ready[k]) begin
                        acc_cnt[k]++;
                        if (rq[k].size() > 0) void'(rq[k].pop_front());
                    end
                end
            end
            for (int k = 0; k < NREQ; k++) begin
                if (rq[k].size() > 0) begin
                    if (!i_Req_Valid[k]) present_cyc[k] = cyc;
                    i_Req_Valid[k]          = 1'b1;
                    i_Req_Byte[k*DW +: DW]  = rq[k][0][7:0];
                    i_Req_Last[k]           = rq[k][0][8];
                end else begin
                    i_Req_Valid[k] = 1'b0;
                    i_Req_Last[k]  = 1'b0;
                end
            end
        end
    end

    // Transmitter model: done pulse FRAME cycles after each start pulse.
    initial begin
        bit ab;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && o_Tx_Ready === 1'b1) begin
                ab = 1'b0;
                for (int i = 0; i < FRAME; i++) begin
                    @(negedge clk);
                    if (abort) begin
                        ab = 1'b1;
                        break;
                    end
                end
                if (!ab) begin
                    i_Tx_Done = 1'b1;
                    done_cyc  = cyc;
                    done_seen = 1'b1;
                    @(negedge clk);
                    i_Tx_Done = 1'b0;
                end
            end
        end
    end

    // Reset asserted mid-cycle; outputs must clear immediately.
    task automatic apply_reset();
        @(posedge clk);
        #2;
        abort   = 1'b1;
        reset_n = 1'b0;
        #1;
        check("rst_tx_ready",  32'(o_Tx_Ready),  32'd0);
        check("rst_req_ready", 32'(o_Req_Ready), 32'd0);
        check("rst_tx_byte",   32'(o_Tx_Byte),   32'd0);
        check("rst_grant",     32'(o_Grant),     32'd0);
        check("rst_busy",      32'(o_Busy),      32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || pending() != 0 || o_Busy) && n < DRAIN_MAX) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, 32'(n < DRAIN_MAX), 32'd1);
        repeat (3) @(negedge clk);
        check({name, "_idle_busy"},  32'(o_Busy),     32'd0);
        check({name, "_idle_ready"}, 32'(o_Tx_Ready), 32'd0);
    endtask

    task automatic push_exp(input logic [1:0] g, input byte_t b);
        exp_t e;
        e.g = g;
        e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic clear_acc();
        for (int k = 0; k < NREQ; k++) acc_cnt[k] = 0;
    endtask

    initial begin
        vt[0] = '{rst: 1'b1, mask: 4'b0001, bytes: {8'h00, 8'h00, 8'h00, 8'h55}, n: 3'd1,
                  eg: {2'd0, 2'd0, 2'd0, 2'd0}, eb: {8'h00, 8'h00, 8'h00, 8'h55}};
        vt[1] = '{rst: 1'b1, mask: 4'b1111, bytes: {8'h32, 8'h22, 8'h10, 8'h01}, n: 3'd4,
                  eg: {2'd3, 2'd2, 2'd1, 2'd0}, eb: {8'h32, 8'h22, 8'h10, 8'h01}};
        vt[2] = '{rst: 1'b0, mask: 4'b1010, bytes: {8'h33, 8'h00, 8'h11, 8'h00}, n: 3'd2,
                  eg: {2'd0, 2'd0, 2'd3, 2'd1}, eb: {8'h00, 8'h00, 8'h33, 8'h11}};
        vt[3] = '{rst: 1'b1, mask: 4'b0100, bytes: {8'h00, 8'h77, 8'h00, 8'h00}, n: 3'd1,
                  eg: {2'd0, 2'd0, 2'd0, 2'd2}, eb: {8'h00, 8'h00, 8'h00, 8'h77}};
        vt[4] = '{rst: 1'b0, mask: 4'b1001, bytes: {8'hC3, 8'h00, 8'h00, 8'hC0}, n: 3'd2,
                  eg: {2'd0, 2'd0, 2'd0, 2'd3}, eb: {8'h00, 8'h00, 8'hC0, 8'hC3}};
        vt[5] = '{rst: 1'b0, mask: 4'b0110, bytes: {8'h00, 8'hA5, 8'h5A, 8'h00}, n: 3'd2,
                  eg: {2'd0, 2'd0, 2'd2, 2'd1}, eb: {8'h00, 8'h00, 8'hA5, 8'h5A}};

        // Table: one byte per selected requester, expected round-robin order.
        for (int v = 0; v < 6; v++) begin
            if (vt[v].rst) apply_reset();
            @(posedge clk);
            #1;
            clear_acc();
            for (int k = 0; k < NREQ; k++)
                if (vt[v].mask[k]) rq[k].push_back({1'b1, vt[v].bytes[k]});
            for (int j = 0; j < int'(vt[v].n); j++)
                push_exp(vt[v].eg[j], vt[v].eb[j]);
            wait_drain($sformatf("vec%0d", v));
            for (int k = 0; k < NREQ; k++)
                check($sformatf("vec%0d_acc%0d", v, k), 32'(acc_cnt[k]), 32'(vt[v].mask[k]));
            if (v == 0) check("latency", 32'(tx_cyc - present_cyc[0]), 32'd1);
        end

        // Single requester streaming: back-to-back frames, 2-clock gap.
        apply_reset();
        @(posedge clk);
        #1;
        clear_acc();
        done_seen = 1'b0;
        gap_chk   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rq[2].push_back({1'b1, 8'(8'h80 + i)});
            push_exp(2'd2, 8'(8'h80 + i));
        end
        wait_drain("stream");
        gap_chk = 1'b0;
        check("stream_acc2", 32'(acc_cnt[2]), 32'd8);

        // Reset during WAIT abandons the frame and restarts the pointer at 0.
        apply_reset();
        @(posedge clk);
        #1;
        clear_acc();
        rq[1].push_back({1'b1, 8'h3C});
        push_exp(2'd1, 8'h3C);
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("midwait_busy", 32'(o_Busy), 32'd1);
        @(posedge clk);
        #1;
        rq[0].push_back({1'b1, 8'hAA});
        rq[3].push_back({1'b1, 8'h3D});
        push_exp(2'd0, 8'hAA);
        push_exp(2'd3, 8'h3D);
        apply_reset();
        wait_drain("midwait");
        check("midwait_acc0", 32'(acc_cnt[0]), 32'd1);
        check("midwait_acc1", 32'(acc_cnt[1]), 32'd1);
        check("midwait_acc3", 32'(acc_cnt[3]), 32'd1);

        // Multi-byte message from req0 while req1 is continuously valid.
        apply_reset();
        @(posedge clk);
        #1;
        clear_acc();
        rq[0].push_back({1'b0, 8'hD0});
        rq[0].push_back({1'b0, 8'hD1});
        rq[0].push_back({1'b1, 8'hD2});
        rq[1].push_back({1'b1, 8'hE0});
        rq[1].push_back({1'b1, 8'hE1});
`ifdef UART_ARB_LOCK_EN
        push_exp(2'd0, 8'hD0);
        push_exp(2'd0, 8'hD1);
        push_exp(2'd0, 8'hD2);
        push_exp(2'd1, 8'hE0);
        push_exp(2'd1, 8'hE1);
`else
        push_exp(2'd0, 8'hD0);
        push_exp(2'd1, 8'hE0);
        push_exp(2'd0, 8'hD1);
        push_exp(2'd1, 8'hE1);
        push_exp(2'd0, 8'hD2);
`endif
        wait_drain("lock");
        check("lock_acc0", 32'(acc_cnt[0]), 32'd3);
        check("lock_acc1", 32'(acc_cnt[1]), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        checks++;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
